// File: rtl/tensor_tile_stream_buf.sv
// rtl/tensor_tile_stream_buf.sv - channel-tagging buffered stream bridge between read and write DMA
// Accepts per-channel beat counts after a start pulse and drains tagged beats through a fall-through FIFO.
module tensor_tile_stream_buf #(
   parameter int DATA_W = 256,
   parameter int DEPTH  = 16,
   parameter int NUM_CH = 3,
   parameter int LEN_W  = 16,
   parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cfg_start,
   input  logic [NUM_CH*LEN_W-1:0]   cfg_len,
   input  logic [DATA_W-1:0]         s_dat,
   input  logic                      s_valid,
   output logic                      s_ready,
   output logic [DATA_W-1:0]         m_dat,
   output logic [CH_W-1:0]           m_ch,
   output logic                      m_last,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic                      busy,
   output logic                      done,
   output logic [$clog2(DEPTH):0]    level
);

   localparam int AW    = $clog2(DEPTH);
   localparam int SUM_W = LEN_W + $clog2(NUM_CH) + 1;
   localparam int EW    = DATA_W + CH_W + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DRAIN, ST_DONE} state_t;

   state_t            state, state_nxt;
   logic [LEN_W-1:0]  len_q [NUM_CH];
   logic [CH_W-1:0]   in_ch, first_ch, next_ch;
   logic              has_next;
   logic [LEN_W-1:0]  in_cnt, cur_len;
   logic [SUM_W-1:0]  len_sum;
   logic [EW-1:0]     mem [DEPTH];
   logic [EW-1:0]     head;
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       count;
   logic              push, pop, full, empty, beat_last, start_ok;

   // Channel scan: descending loop leaves the lowest qualifying index as the winner.
   always_comb begin
      len_sum  = '0;
      first_ch = '0;
      next_ch  = in_ch;
      has_next = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (cfg_len[i*LEN_W +: LEN_W] != '0) first_ch = CH_W'(i);
         if (i > int'(in_ch) && len_q[i] != '0) begin
            next_ch  = CH_W'(i);
            has_next = 1'b1;
         end
      end
      for (int i = 0; i < NUM_CH; i++) begin
         len_sum = len_sum + SUM_W'(cfg_len[i*LEN_W +: LEN_W]);
      end
   end

   assign cur_len   = len_q[in_ch];
   assign beat_last = (in_cnt == cur_len - LEN_W'(1));
   assign full      = (count == (AW+1)'(DEPTH));
   assign empty     = (count == '0);
   assign s_ready   = (state == ST_FILL) && !full;
   assign push      = s_valid && s_ready;
   assign m_valid   = !empty;
   assign pop       = m_valid && m_ready;
   assign start_ok  = (state == ST_IDLE) && cfg_start;
   assign head      = mem[rd_ptr];
   assign m_dat     = empty ? '0 : head[DATA_W-1:0];
   assign m_ch      = empty ? '0 : head[DATA_W +: CH_W];
   assign m_last    = empty ? 1'b0 : head[EW-1];
   assign level     = count;
   assign busy      = (state == ST_FILL) || (state == ST_DRAIN);
   assign done      = (state == ST_DONE);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (cfg_start) state_nxt = (len_sum == '0) ? ST_DONE : ST_FILL;
         ST_FILL:  if (push && beat_last && !has_next) state_nxt = ST_DRAIN;
         // Leave as the final pop retires so done lands the cycle after it.
         ST_DRAIN: if (count == (AW+1)'(pop)) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         in_ch  <= '0;
         in_cnt <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < NUM_CH; i++) len_q[i] <= '0;
      end else begin
         state <= state_nxt;
         if (start_ok) begin
            for (int i = 0; i < NUM_CH; i++) len_q[i] <= cfg_len[i*LEN_W +: LEN_W];
            in_ch  <= first_ch;
            in_cnt <= '0;
         end else if (push) begin
            if (beat_last) begin
               in_cnt <= '0;
               in_ch  <= next_ch;
            end else begin
               in_cnt <= in_cnt + LEN_W'(1);
            end
         end
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {beat_last, in_ch, s_dat};
   end

endmodule

// File: tb/tb_tensor_tile_stream_buf.sv
// tb/tb_tensor_tile_stream_buf.sv - randomized self-checking bench for tensor_tile_stream_buf
// Each job's expected beat list is built from the lengths alone and compared beat by beat.
module tb_tensor_tile_stream_buf;

   localparam int DATA_W = 256;
   localparam int DEPTH  = 16;
   localparam int NUM_CH = 3;
   localparam int LEN_W  = 16;
   localparam int CH_W   = 2;
   localparam int LVL_W  = 5;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     cfg_start;
   logic [NUM_CH*LEN_W-1:0]  cfg_len;
   logic [DATA_W-1:0]        s_dat;
   logic                     s_valid;
   logic                     s_ready;
   logic [DATA_W-1:0]        m_dat;
   logic [CH_W-1:0]          m_ch;
   logic                     m_last;
   logic                     m_valid;
   logic                     m_ready;
   logic                     busy;
   logic                     done;
   logic [LVL_W-1:0]         level;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tensor_tile_stream_buf #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .LEN_W(LEN_W), .CH_W(CH_W)
   ) dut (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_len(cfg_len),
      .s_dat(s_dat), .s_valid(s_valid), .s_ready(s_ready),
      .m_dat(m_dat), .m_ch(m_ch), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
      .busy(busy), .done(done), .level(level)
   );

   task automatic check_eq(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] rand_word();
      logic [DATA_W-1:0] w;
      for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   // rdy_mode: 0 = always ready, 1 = random valid/ready, 2 = sink stalled for 30 cycles
   task automatic run_job(input int l0, input int l1, input int l2, input int rdy_mode,
                          input bit start2, input bit do_rst);
      int lens[NUM_CH];
      logic [DATA_W-1:0] in_q[$];
      logic [DATA_W-1:0] exp_dat[$];
      int exp_ch[$];
      bit exp_last[$];
      logic [DATA_W-1:0] d;
      int total, in_idx, out_idx, last_pop, done_cnt, max_lvl, tail;
      lens = '{l0, l1, l2};
      for (int ch = 0; ch < NUM_CH; ch++) begin
         for (int k = 0; k < lens[ch]; k++) begin
            d = rand_word();
            in_q.push_back(d);
            exp_dat.push_back(d);
            exp_ch.push_back(ch);
            exp_last.push_back(k == lens[ch] - 1);
         end
      end
      total = in_q.size();
      in_idx = 0; out_idx = 0; last_pop = -10; done_cnt = 0; max_lvl = 0; tail = 0;

      @(negedge clk);
      cfg_start = 1'b1;
      for (int ch = 0; ch < NUM_CH; ch++) cfg_len[ch*LEN_W +: LEN_W] = LEN_W'(lens[ch]);
      s_valid = 1'b0;
      s_dat   = rand_word();
      m_ready = 1'b0;
      #1;
      check_eq("idle_busy", busy, 0);
      check_eq("idle_s_ready", s_ready, 0);

      for (int cyc = 1; cyc < 3000; cyc++) begin
         @(negedge clk);
         cfg_start = start2 && (cyc == 3);
         if (cfg_start) for (int ch = 0; ch < NUM_CH; ch++) cfg_len[ch*LEN_W +: LEN_W] = LEN_W'(7);
         s_valid = (in_idx < total) && (rdy_mode != 1 || $urandom_range(0, 3) != 0);
         s_dat   = (in_idx < total) ? in_q[in_idx] : rand_word();
         m_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : (cyc > 30);
         if (do_rst && level == 5) begin
            rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            #1;
            check_eq("rst_level", level, 0);
            check_eq("rst_m_valid", m_valid, 0);
            check_eq("rst_busy", busy, 0);
            check_eq("rst_done", done, 0);
            return;
         end
         #1;
         if (cyc == 1 && total > 0) check_eq("busy_after_start", busy, 1);
         if (in_idx == total) check_eq("s_ready_after_fill", s_ready, 0);
         if (level == DEPTH) check_eq("s_ready_full", s_ready, 0);
         check_eq("level_bound", level > DEPTH, 0);
         if (total == 0) check_eq("zero_m_valid", m_valid, 0);
         if (int'(level) > max_lvl) max_lvl = int'(level);
         if (s_valid && s_ready) in_idx++;
         if (m_valid && m_ready) begin
            if (out_idx < total) begin
               check_eq("m_dat", m_dat, exp_dat[out_idx]);
               check_eq("m_ch", m_ch, exp_ch[out_idx]);
               check_eq("m_last", m_last, exp_last[out_idx]);
            end else begin
               check_eq("extra_beat", 1, 0);
            end
            out_idx++;
            last_pop = cyc;
         end
         if (done) begin
            done_cnt++;
            check_eq("done_timing", cyc, (total == 0) ? 1 : last_pop + 1);
            check_eq("busy_at_done", busy, 0);
         end
         if (done_cnt > 0) tail++;
         if (tail > 4) break;
      end
      cfg_start = 1'b0;
      check_eq("beats_in", in_idx, total);
      check_eq("beats_out", out_idx, total);
      check_eq("done_count", done_cnt, 1);
      if (rdy_mode == 2 && total >= DEPTH) check_eq("level_peak", max_lvl, DEPTH);
   endtask

   initial begin
      rst = 1'b1; cfg_start = 1'b0; cfg_len = '0; s_dat = '0; s_valid = 1'b0; m_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_eq("reset_s_ready", s_ready, 0);
      check_eq("reset_m_valid", m_valid, 0);
      check_eq("reset_busy", busy, 0);
      check_eq("reset_done", done, 0);
      check_eq("reset_level", level, 0);
      check_eq("reset_m_dat", m_dat, 0);
      check_eq("reset_m_ch", m_ch, 0);
      check_eq("reset_m_last", m_last, 0);
      rst = 1'b0;

      run_job(4, 3, 2, 0, 1'b0, 1'b0);
      run_job(0, 0, 20, 2, 1'b0, 1'b0);
      run_job(2, 0, 3, 0, 1'b0, 1'b0);
      run_job(0, 0, 0, 0, 1'b0, 1'b0);
      run_job(3, 4, 2, 1, 1'b1, 1'b0);
      run_job(6, 4, 2, 2, 1'b0, 1'b1);
      run_job(2, 2, 2, 1, 1'b0, 1'b0);
      for (int j = 0; j < 8; j++) begin
         run_job($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 2), 1'b0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
